alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 32-bit alu instance between NUM_REQUESTERS clients, e.g. the execute stage and the
//  branch/address-calculation path, so the core needs only one ALU. Each client uses a valid/ready request
//  channel and a valid/ready response channel. Arbitration is round-robin. Each result is registered, so a
//  granted request has exactly one cycle of latency. The block accepts one request per cycle when no response is stalled.
// PARAMETERS
//  NUM_REQUESTERS  2   number of clients sharing the ALU (>=2)
// PORTS
//  clock              in   1           single clock; all state updates on rising edge
//  reset              in   1           synchronous, active-high
//  request_valid      in   [N]         client i presents an operation
//  request_ready      out  [N]         client i's request is accepted this cycle
//  request_operation  in   [N] alu_operations::alu_operation_t   per-client opcode
//  request_operand_1  in   [N][32]     per-client first operand
//  request_operand_2  in   [N][32]     per-client second operand (shift amount = [4:0])
//  response_valid     out  [N]         response_result belongs to client i (one-hot or zero)
//  response_ready     in   [N]         client i consumes the response
//  response_result    out  32          registered ALU result
// BEHAVIOUR
//  Reset: response_valid=0, response_result=0, holding=0, priority pointer=0. A held response is discarded.
//  Any response in flight during reset is lost, and clients must re-issue the request.
//  Grant (combinational): among request_valid, select the first index at or after the pointer, wrapping at N-1->0.
//  Accept enable = !holding | response_fire, where response_fire = response_valid[owner] & response_ready[owner].
//  request_ready[g] = grant valid & accept enable. All other request_ready bits are 0.
//  request_ready may depend combinationally on request_valid and response_ready.
//  On accept (edge T): response_result <= alu(selected op, operands); owner <= g; holding <= 1;
//  pointer <= (g+1) mod N.
//  At T+1: response_valid[g]=1. The response is held stable until response_ready[g]=1.
//  On response_fire without a new accept: holding <= 0 and response_valid falls next cycle.
//  On response_fire with a new accept in the same cycle: the new result and owner load, and response_valid stays
//  high for the new owner. Back-to-back throughput is 1 operation per cycle.
//  While a response is held and not consumed, all request_ready bits are 0 (backpressure).
//  Pending requests must hold valid and payload stable until ready. Changing the payload before ready is a client error.
//  response_ready from non-owner clients is ignored. The pointer advances only on accept, never while idle.
//  An opcode outside the defined operations yields result 0, as the alu defines.
//  Arithmetic follows the alu exactly: 32-bit wrap-around add/subtract, signed and unsigned compares.
// STRUCTURE
//  Reuse package alu_operations (alu_operation_t). Add localparam-derived requester index type
//  logic [$clog2(NUM_REQUESTERS)-1:0] inside the module. No new package.
//  Sub-module: round_robin_arbiter #(N) (request vector, pointer -> one-hot grant, grant index, any).
//  The block instantiates alu once, with the operation and operands muxed by grant index.
// TESTING
//  1 Reset, no valid -> request_ready=0, response_valid=0, response_result=0 for all cycles.
//  2 Only req0 valid at T: Add 5,7 -> request_ready[0]=1 at T; response_valid[0]=1, result=12 at T+1.
//  3 Both clients valid, response_ready=all 1, req0 Add 1,1 and req1 Subtract 3,5:
//    grants 0,1,0,1 starting at 0; results 2, 0xFFFFFFFE alternate each cycle.
//  4 Backpressure: req0 response_ready=0 for 3 cycles -> result held, request_ready=0 while req1 waits.
//    When response_ready rises, req1 is accepted in the same cycle and its response appears the next cycle.
//  5 req1 alone: Shift_Right_Arithmetic 0x80000000, 4 -> 0xF8000000.
//    Set_Less_Than_Unsigned 0xFFFFFFFF, 1 -> 0.
//  6 Reset while a response is held -> response_valid=0 on the next cycle.
//    After reset, with both clients valid, client 0 is granted first.

Source files
------------

// File: rtl/alu_operations.sv
// Operation encoding shared by the ALU and every block that issues ALU work.
package alu_operations;

  typedef enum logic [3:0] {
    Add                    = 4'd0,
    Subtract               = 4'd1,
    Shift_Left_Logical     = 4'd2,
    Shift_Right_Logical    = 4'd3,
    Shift_Right_Arithmetic = 4'd4,
    Set_Less_Than          = 4'd5,
    Set_Less_Than_Unsigned = 4'd6,
    Bitwise_And            = 4'd7,
    Bitwise_Or             = 4'd8,
    Bitwise_Xor            = 4'd9
  } alu_operation_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; encodings outside alu_operation_t produce zero.
module alu
  import alu_operations::*;
(
  input  alu_operation_t operation,
  input  logic [31:0]    operand_1,
  input  logic [31:0]    operand_2,
  output logic [31:0]    result
);

  logic [4:0] shift_amount;

  assign shift_amount = operand_2[4:0];

  always_comb begin
    result = '0;
    case (operation)
      Add:                    result = operand_1 + operand_2;
      Subtract:               result = operand_1 - operand_2;
      Shift_Left_Logical:     result = operand_1 << shift_amount;
      Shift_Right_Logical:    result = operand_1 >> shift_amount;
      Shift_Right_Arithmetic: result = $signed(operand_1) >>> shift_amount;
      Set_Less_Than:          result = {31'd0, $signed(operand_1) < $signed(operand_2)};
      Set_Less_Than_Unsigned: result = {31'd0, operand_1 < operand_2};
      Bitwise_And:            result = operand_1 & operand_2;
      Bitwise_Or:             result = operand_1 | operand_2;
      Bitwise_Xor:            result = operand_1 ^ operand_2;
      default:                result = '0;
    endcase
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Picks the first active request at or after the pointer, wrapping from N-1 to 0.
module round_robin_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_index,
  output logic          any
);

  int unsigned idx;

  always_comb begin
    grant       = '0;
    grant_index = '0;
    any         = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(pointer) + k) % N;
      if (!any && request[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        grant_index = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQUESTERS valid/ready clients,
// with a single registered response slot and one cycle of latency.
module alu_arbiter
  import alu_operations::*;
#(
  parameter int unsigned NUM_REQUESTERS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request_valid,
  output logic [NUM_REQUESTERS-1:0] request_ready,
  input  alu_operation_t            request_operation [NUM_REQUESTERS],
  input  logic [31:0]               request_operand_1 [NUM_REQUESTERS],
  input  logic [31:0]               request_operand_2 [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] response_valid,
  input  logic [NUM_REQUESTERS-1:0] response_ready,
  output logic [31:0]               response_result
);

  localparam int unsigned IW = $clog2(NUM_REQUESTERS);
  typedef logic [IW-1:0] requester_index_t;

  logic [NUM_REQUESTERS-1:0] response_valid_q, response_valid_d;
  logic [31:0]               result_q, result_d;
  requester_index_t          owner_q, owner_d;
  requester_index_t          pointer_q, pointer_d;

  logic [NUM_REQUESTERS-1:0] grant;
  requester_index_t          grant_index;
  logic                      grant_any;
  logic                      holding;
  logic                      response_fire;
  logic                      accept_enable;
  logic                      accept;
  logic [31:0]               alu_result;

  round_robin_arbiter #(
    .N (NUM_REQUESTERS),
    .IW(IW)
  ) u_round_robin_arbiter (
    .request    (request_valid),
    .pointer    (pointer_q),
    .grant      (grant),
    .grant_index(grant_index),
    .any        (grant_any)
  );

  alu u_alu (
    .operation(request_operation[grant_index]),
    .operand_1(request_operand_1[grant_index]),
    .operand_2(request_operand_2[grant_index]),
    .result   (alu_result)
  );

  // A consumed response frees the slot in the same cycle, so a new request can load behind it.
  assign holding       = |response_valid_q;
  assign response_fire = holding & response_ready[owner_q];
  assign accept_enable = ~holding | response_fire;
  assign accept        = grant_any & accept_enable;
  assign request_ready = accept ? grant : '0;

  always_comb begin
    response_valid_d = response_valid_q;
    result_d         = result_q;
    owner_d          = owner_q;
    pointer_d        = pointer_q;
    if (accept) begin
      response_valid_d = grant;
      result_d         = alu_result;
      owner_d          = grant_index;
      pointer_d        = (grant_index == requester_index_t'(NUM_REQUESTERS - 1))
                         ? '0 : requester_index_t'(grant_index + 1'b1);
    end else if (response_fire) begin
      response_valid_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      response_valid_q <= '0;
      result_q         <= '0;
      owner_q          <= '0;
      pointer_q        <= '0;
    end else begin
      response_valid_q <= response_valid_d;
      result_q         <= result_d;
      owner_q          <= owner_d;
      pointer_q        <= pointer_d;
    end
  end

  assign response_valid  = response_valid_q;
  assign response_result = result_q;

  response_one_hot : assert property (@(posedge clock) disable iff (reset)
    $onehot0(response_valid_q));

  grant_one_hot : assert property (@(posedge clock) disable iff (reset)
    $onehot0(request_ready));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a spec-level model checked every cycle plus literal expectations.
module tb_alu_arbiter;
  import alu_operations::*;

  localparam int N = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   request_valid = '0;
  logic [N-1:0]   request_ready;
  alu_operation_t request_operation [N];
  logic [31:0]    request_operand_1 [N];
  logic [31:0]    request_operand_2 [N];
  logic [N-1:0]   response_valid;
  logic [N-1:0]   response_ready = '0;
  logic [31:0]    response_result;

  int  checks = 0;
  int  passes = 0;
  bit  done   = 1'b0;

  always #5 clock = ~clock;

  alu_arbiter #(.NUM_REQUESTERS(N)) dut (
    .clock            (clock),
    .reset            (reset),
    .request_valid    (request_valid),
    .request_ready    (request_ready),
    .request_operation(request_operation),
    .request_operand_1(request_operand_1),
    .request_operand_2(request_operand_2),
    .response_valid   (response_valid),
    .response_ready   (response_ready),
    .response_result  (response_result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] alu_model(alu_operation_t op, logic [31:0] a, logic [31:0] b);
    int unsigned sh = 32'(b[4:0]);
    case (op)
      Add:                    return a + b;
      Subtract:               return a + ~b + 32'd1;
      Shift_Left_Logical:     return a << sh;
      Shift_Right_Logical:    return a >> sh;
      Shift_Right_Arithmetic: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      Set_Less_Than:          return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      Set_Less_Than_Unsigned: return (a < b) ? 32'd1 : 32'd0;
      Bitwise_And:            return a & b;
      Bitwise_Or:             return a | b;
      Bitwise_Xor:            return a ^ b;
      default:                return 32'd0;
    endcase
  endfunction

  // Model state: one response slot, its owner, and the round-robin start point.
  bit          m_valid  = 1'b0;
  int          m_owner  = 0;
  logic [31:0] m_result = '0;
  int          m_ptr    = 0;

  always @(negedge clock) begin
    if (!done) begin
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_rv;
      bit fire;
      int g;
      exp_rv = m_valid ? N'(1 << m_owner) : '0;
      fire   = m_valid && response_ready[m_owner];
      g      = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && request_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_ready = ((!m_valid || fire) && g >= 0) ? N'(1 << g) : '0;
      check("model.request_ready", 32'(request_ready), 32'(exp_ready));
      check("model.response_valid", 32'(response_valid), 32'(exp_rv));
      check("model.response_result", response_result, m_result);
      if (reset) begin
        m_valid = 1'b0; m_owner = 0; m_result = '0; m_ptr = 0;
      end else if (exp_ready != '0) begin
        m_result = alu_model(request_operation[g], request_operand_1[g], request_operand_2[g]);
        m_owner  = g;
        m_valid  = 1'b1;
        m_ptr    = (g + 1) % N;
      end else if (fire) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic drive(input int i, input logic v, input alu_operation_t op,
                       input logic [31:0] a, input logic [31:0] b);
    request_valid[i]     = v;
    request_operation[i] = op;
    request_operand_1[i] = a;
    request_operand_2[i] = b;
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] rdy,
                            input logic [N-1:0] vld, input logic [31:0] res);
    check({tag, ".request_ready"}, 32'(request_ready), 32'(rdy));
    check({tag, ".response_valid"}, 32'(response_valid), 32'(vld));
    check({tag, ".response_result"}, response_result, res);
  endtask

  logic [N-1:0]   t3_rdy [4];
  alu_operation_t t5_op  [5];
  logic [31:0]    t5_a   [5];
  logic [31:0]    t5_b   [5];
  logic [31:0]    t5_exp [5];

  initial begin
    drive(0, 1'b0, Add, '0, '0);
    drive(1, 1'b0, Add, '0, '0);

    // Reset with nothing requested
    repeat (3) begin
      step(); sample();
      expect_out("reset", 2'b00, 2'b00, 32'd0);
    end

    // Single request from client 0
    step(); reset = 1'b0; drive(0, 1'b1, Add, 32'd5, 32'd7);
    sample(); check("t2.accept", 32'(request_ready), 32'h1);
    step(); drive(0, 1'b0, Add, '0, '0);
    sample(); expect_out("t2.resp", 2'b00, 2'b01, 32'd12);
    step(); response_ready = 2'b01;
    sample();
    step();
    sample(); check("t2.drain", 32'(response_valid), 32'h0);

    // Alternating grants from a fresh pointer
    step(); reset = 1'b1;
    sample();
    step(); reset = 1'b0; response_ready = 2'b11;
    drive(0, 1'b1, Add, 32'd1, 32'd1);
    drive(1, 1'b1, Subtract, 32'd3, 32'd5);
    t3_rdy[0] = 2'b01; t3_rdy[1] = 2'b10; t3_rdy[2] = 2'b01; t3_rdy[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("t3.grant", 32'(request_ready), 32'(t3_rdy[k]));
      if (k > 0) begin
        check("t3.owner", 32'(response_valid), 32'(t3_rdy[k-1]));
        check("t3.result", response_result, (k % 2 == 1) ? 32'd2 : 32'hFFFF_FFFE);
      end
      step();
    end
    drive(0, 1'b0, Add, '0, '0);
    drive(1, 1'b0, Add, '0, '0);
    sample(); expect_out("t3.last", 2'b00, 2'b10, 32'hFFFF_FFFE);
    step();
    sample(); check("t3.drain", 32'(response_valid), 32'h0);

    // Backpressure from client 0 while client 1 waits
    step(); response_ready = 2'b10;
    drive(0, 1'b1, Add, 32'd10, 32'd20);
    drive(1, 1'b1, Bitwise_Or, 32'h0000_00F0, 32'h0000_000F);
    sample(); check("t4.grant0", 32'(request_ready), 32'h1);
    step(); drive(0, 1'b0, Add, '0, '0);
    sample(); expect_out("t4.held0", 2'b00, 2'b01, 32'd30);
    repeat (2) begin
      step(); sample();
      expect_out("t4.held", 2'b00, 2'b01, 32'd30);
    end
    step(); response_ready = 2'b11;
    sample(); expect_out("t4.release", 2'b10, 2'b01, 32'd30);
    step(); drive(1, 1'b0, Add, '0, '0);
    sample(); expect_out("t4.resp1", 2'b00, 2'b10, 32'h0000_00FF);
    step();
    sample(); check("t4.drain", 32'(response_valid), 32'h0);

    // Client 1 alone, back to back, including boundary operations
    t5_op[0] = Shift_Right_Arithmetic;  t5_a[0] = 32'h8000_0000; t5_b[0] = 32'd4; t5_exp[0] = 32'hF800_0000;
    t5_op[1] = Set_Less_Than;           t5_a[1] = 32'hFFFF_FFFF; t5_b[1] = 32'd1; t5_exp[1] = 32'd1;
    t5_op[2] = Set_Less_Than_Unsigned;  t5_a[2] = 32'hFFFF_FFFF; t5_b[2] = 32'd1; t5_exp[2] = 32'd0;
    t5_op[3] = Add;                     t5_a[3] = 32'h7FFF_FFFF; t5_b[3] = 32'd1; t5_exp[3] = 32'h8000_0000;
    t5_op[4] = alu_operation_t'(4'd15); t5_a[4] = 32'd5;         t5_b[4] = 32'd7; t5_exp[4] = 32'd0;
    for (int k = 0; k < 5; k++) begin
      step(); drive(1, 1'b1, t5_op[k], t5_a[k], t5_b[k]);
      sample(); check("t5.grant", 32'(request_ready), 32'h2);
      if (k > 0) begin
        check("t5.owner", 32'(response_valid), 32'h2);
        check("t5.result", response_result, t5_exp[k-1]);
      end
    end
    step(); drive(1, 1'b0, Add, '0, '0);
    sample(); expect_out("t5.last", 2'b00, 2'b10, t5_exp[4]);
    step();
    sample(); check("t5.drain", 32'(response_valid), 32'h0);

    // Reset while a response is held
    step(); response_ready = 2'b00; drive(0, 1'b1, Add, 32'd2, 32'd2);
    sample(); check("t6.grant", 32'(request_ready), 32'h1);
    step(); drive(0, 1'b0, Add, '0, '0);
    sample(); expect_out("t6.held", 2'b00, 2'b01, 32'd4);
    step(); reset = 1'b1;
    drive(0, 1'b1, Add, 32'd3, 32'd4);
    drive(1, 1'b1, Subtract, 32'd9, 32'd4);
    sample(); expect_out("t6.in_reset", 2'b00, 2'b01, 32'd4);
    step(); reset = 1'b0;
    sample(); expect_out("t6.after_reset", 2'b01, 2'b00, 32'd0);
    step(); response_ready = 2'b11; drive(0, 1'b0, Add, '0, '0);
    sample(); expect_out("t6.first", 2'b10, 2'b01, 32'd7);
    step(); drive(1, 1'b0, Add, '0, '0);
    sample(); expect_out("t6.second", 2'b00, 2'b10, 32'd5);
    step();
    sample(); check("t6.drain", 32'(response_valid), 32'h0);

    repeat (2) step();
    done = 1'b1;
    #20;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got %0d/%0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
